// File: rtl/tlb_refill_ctrl_pkg.sv
// Shared constants, PTE field positions and FSM encoding for the TLB refill controller.
package tlb_refill_ctrl_pkg;

  localparam int unsigned NUM_SETS       = 16;
  localparam int unsigned NUM_WAYS       = 4;
  localparam int unsigned SET_INDEX_BITS = 4;
  localparam int unsigned LRU_BITS       = 4;
  localparam int unsigned VPN_BITS       = 20;
  localparam int unsigned PPN_BITS       = 20;

  localparam int unsigned PTE_VALID_BIT  = 0;
  localparam int unsigned PTE_PERM_LSB   = 1;
  localparam int unsigned PTE_PPN_LSB    = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_SET   = 3'd1,
    ST_PTW_REQ  = 3'd2,
    ST_PTW_WAIT = 3'd3,
    ST_WRITE    = 3'd4,
    ST_DONE     = 3'd5
  } refill_state_e;

endpackage

// File: rtl/tlb_victim_sel.sv
// Victim way choice: lowest-index invalid way, else minimum use counter (lowest index on ties).
module tlb_victim_sel #(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned LRU_BITS = 4
) (
  input  logic [NUM_WAYS-1:0]          i_valid_bus,
  input  logic [NUM_WAYS*LRU_BITS-1:0] i_lru_bus,
  output logic [1:0]                   o_way
);

  logic                w_found_inv;
  logic [1:0]          w_inv_way;
  logic [1:0]          w_min_way;
  logic [LRU_BITS-1:0] w_min_cnt;

  always_comb begin
    w_found_inv = 1'b0;
    w_inv_way   = '0;
    w_min_way   = '0;
    w_min_cnt   = i_lru_bus[LRU_BITS-1:0];
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!w_found_inv && !i_valid_bus[w]) begin
        w_found_inv = 1'b1;
        w_inv_way   = 2'(w);
      end
      // Strict compare keeps the earlier way on equal counters.
      if (i_lru_bus[w*LRU_BITS +: LRU_BITS] < w_min_cnt) begin
        w_min_cnt = i_lru_bus[w*LRU_BITS +: LRU_BITS];
        w_min_way = 2'(w);
      end
    end
    o_way = w_found_inv ? w_inv_way : w_min_way;
  end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// TLB miss refill controller: set read, victim choice, PTE fetch, one-cycle storage write.
// Optional response timeout enabled by defining TLB_REFILL_TIMEOUT_EN.
module tlb_refill_ctrl
  import tlb_refill_ctrl_pkg::*;
#(
`ifdef TLB_REFILL_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
  parameter int unsigned SET_INDEX_BITS = tlb_refill_ctrl_pkg::SET_INDEX_BITS,
  parameter int unsigned NUM_WAYS       = tlb_refill_ctrl_pkg::NUM_WAYS,
  parameter int unsigned LRU_BITS       = tlb_refill_ctrl_pkg::LRU_BITS,
  parameter logic [31:0] PT_BASE        = 32'h0001_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          miss_valid,
  output logic                          miss_ready,
  input  logic [19:0]                   miss_vpn,
  output logic [SET_INDEX_BITS-1:0]     rd_set_index,
  input  logic [NUM_WAYS-1:0]           rd_valid_bus,
  input  logic [NUM_WAYS*LRU_BITS-1:0]  rd_lru_bus,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [31:0]                   mem_req_addr,
  input  logic                          mem_resp_valid,
  input  logic [31:0]                   mem_resp_data,
  output logic                          wr_en,
  output logic                          update_en,
  output logic [SET_INDEX_BITS-1:0]     wr_set_index,
  output logic [1:0]                    wr_way,
  output logic                          wr_valid,
  output logic [19:0]                   wr_vpn,
  output logic [19:0]                   wr_ppn,
  output logic [1:0]                    wr_perms,
  output logic [LRU_BITS-1:0]           wr_lru_count,
  output logic                          refill_done,
  output logic                          refill_fault,
  output logic [19:0]                   refill_ppn,
  output logic [1:0]                    refill_perms
);

  refill_state_e              r_state;
  logic [19:0]                r_vpn;
  logic [SET_INDEX_BITS-1:0]  r_set;
  logic [1:0]                 r_way;
  logic                       r_fault;
  logic [19:0]                r_ppn;
  logic [1:0]                 r_perms;
  logic [1:0]                 w_victim;
  logic                       w_unused_pte;
`ifdef TLB_REFILL_TIMEOUT_EN
  logic [7:0]                 r_wait_cnt;
`endif

  assign w_unused_pte = &{1'b0, mem_resp_data[PTE_PPN_LSB-1:PTE_PERM_LSB+2]};

  tlb_victim_sel #(
    .NUM_WAYS (NUM_WAYS),
    .LRU_BITS (LRU_BITS)
  ) u_victim_sel (
    .i_valid_bus (rd_valid_bus),
    .i_lru_bus   (rd_lru_bus),
    .o_way       (w_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_vpn      <= '0;
      r_set      <= '0;
      r_way      <= '0;
      r_fault    <= 1'b0;
      r_ppn      <= '0;
      r_perms    <= '0;
`ifdef TLB_REFILL_TIMEOUT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (miss_valid) begin
            r_vpn   <= miss_vpn;
            r_set   <= miss_vpn[SET_INDEX_BITS-1:0];
            r_fault <= 1'b0;
            r_ppn   <= '0;
            r_perms <= '0;
            r_state <= ST_RD_SET;
          end
        end
        ST_RD_SET: begin
          r_way   <= w_victim;
          r_state <= ST_PTW_REQ;
        end
        ST_PTW_REQ: begin
          if (mem_req_ready) begin
`ifdef TLB_REFILL_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
            r_state <= ST_PTW_WAIT;
          end
        end
        ST_PTW_WAIT: begin
          if (mem_resp_valid) begin
            r_ppn   <= mem_resp_data[31:PTE_PPN_LSB];
            r_perms <= mem_resp_data[PTE_PERM_LSB +: 2];
            if (mem_resp_data[PTE_VALID_BIT]) begin
              r_state <= ST_WRITE;
            end else begin
              r_fault <= 1'b1;
              r_state <= ST_DONE;
            end
          end
`ifdef TLB_REFILL_TIMEOUT_EN
          // The counter value is the number of completed wait cycles minus one.
          else if (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            r_fault <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
`endif
        end
        ST_WRITE: r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Every output is decoded from the state and gated registers only.
  always_comb begin
    miss_ready    = (r_state == ST_IDLE);
    rd_set_index  = (r_state == ST_RD_SET) ? r_set : '0;
    mem_req_valid = (r_state == ST_PTW_REQ);
    mem_req_addr  = (r_state == ST_PTW_REQ) ? (PT_BASE + 32'({r_vpn, 2'b00})) : '0;
    wr_en         = (r_state == ST_WRITE);
    update_en     = (r_state == ST_WRITE);
    wr_set_index  = '0;
    wr_way        = '0;
    wr_valid      = 1'b0;
    wr_vpn        = '0;
    wr_ppn        = '0;
    wr_perms      = '0;
    wr_lru_count  = '0;
    if (r_state == ST_WRITE) begin
      wr_set_index = r_set;
      wr_way       = r_way;
      wr_valid     = 1'b1;
      wr_vpn       = r_vpn;
      wr_ppn       = r_ppn;
      wr_perms     = r_perms;
      wr_lru_count = LRU_BITS'(1);
    end
    refill_done   = (r_state == ST_DONE);
    refill_fault  = (r_state == ST_DONE) && r_fault;
    refill_ppn    = (r_state == ST_DONE) ? r_ppn : '0;
    refill_perms  = (r_state == ST_DONE) ? r_perms : '0;
  end

endmodule
